// File: rtl/activation_fc_pipe.sv
// -----------------------------------------------------------------------------
// activation_fc_pipe
//
// Two-stage, multi-lane activation pipeline sitting between the FC
// accumulator and the output buffer.
//   S1 (shift):    rounding arithmetic right shift of each IN_WIDTH lane,
//                  computed at IN_WIDTH+1 bits (round-half-up). The beat's
//                  mode/clip configuration is captured alongside the data.
//   S2 (activate): per-lane activation (bypass / ReLU / leaky / clipped)
//                  followed by saturation to OUT_WIDTH.
// Both stages use valid/ready handshakes with no bubble while streaming.
//
// Optional feature (macro ACTIVATION_FC_PIPE_SAT_STATS_EN): per-frame count
// of lanes that saturated, reported with a one-cycle valid pulse on the
// output transfer that carries the frame's last beat.
//
// Ports:
//   clk                clock, rising edge
//   rst                asynchronous active-high reset
//   cfg_mode_i         0 bypass, 1 ReLU, 2 leaky ReLU, 3 clipped ReLU
//   cfg_shift_i        requantisation right-shift amount
//   cfg_clip_i         unsigned upper clamp for mode 3 (limited to max pos.)
//   acc_valid_i        input beat valid
//   acc_ready_o        block can accept a beat
//   acc_last_i         last beat of frame
//   acc_result_i       packed signed lanes, lane 0 in LSBs
//   act_valid_o        output beat valid
//   act_ready_i        downstream accepts
//   act_last_o         last flag aligned with its beat
//   act_result_o       packed signed results, lane 0 in LSBs (0 when idle)
//   sat_count_o        (macro only) saturated-lane count of last frame
//   sat_count_valid_o  (macro only) one-cycle pulse when sat_count_o updates
// -----------------------------------------------------------------------------
module activation_fc_pipe #(
  parameter int LANES       = 4,
  parameter int IN_WIDTH    = 16,
  parameter int OUT_WIDTH   = 8,
  parameter int SHIFT_WIDTH = 4,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 cfg_mode_i,
  input  logic [SHIFT_WIDTH-1:0]     cfg_shift_i,
  input  logic [OUT_WIDTH-1:0]       cfg_clip_i,
  input  logic                       acc_valid_i,
  output logic                       acc_ready_o,
  input  logic                       acc_last_i,
  input  logic [LANES*IN_WIDTH-1:0]  acc_result_i,
  output logic                       act_valid_o,
  input  logic                       act_ready_i,
  output logic                       act_last_o,
  output logic [LANES*OUT_WIDTH-1:0] act_result_o
`ifdef ACTIVATION_FC_PIPE_SAT_STATS_EN
  ,
  output logic [15:0]                sat_count_o,
  output logic                       sat_count_valid_o
`endif
);

  // Extended width so the rounding add can never overflow.
  localparam int EXT_WIDTH = IN_WIDTH + 1;

  localparam logic signed [EXT_WIDTH-1:0] EXT_MAX = EXT_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [EXT_WIDTH-1:0] EXT_MIN = EXT_WIDTH'(-(2 ** (OUT_WIDTH - 1)));
  localparam logic [OUT_WIDTH-1:0]        OUT_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0]        OUT_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_RELU   = 2'd1,
    MODE_LEAKY  = 2'd2,
    MODE_CLIP   = 2'd3
  } mode_t;

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic                        s1_valid_reg;
  logic                        s1_last_reg;
  mode_t                       s1_mode_reg;
  logic [OUT_WIDTH-1:0]        s1_clip_reg;
  logic signed [EXT_WIDTH-1:0] s1_r_reg [LANES];

  logic                        s2_valid_reg;
  logic                        s2_last_reg;
  logic [LANES*OUT_WIDTH-1:0]  s2_result_reg;

  logic signed [EXT_WIDTH-1:0] s1_r_next [LANES];
  logic [LANES*OUT_WIDTH-1:0]  s2_result_next;
  logic [OUT_WIDTH-1:0]        clip_lim;
  logic                        s2_load;

  // Handshake: S2 refills when empty or draining; S1 may accept whenever it is
  // empty or is itself moving into S2 this cycle.
  assign s2_load     = !s2_valid_reg || act_ready_i;
  assign acc_ready_o = !s1_valid_reg || s2_load;

  // Clip is unsigned; anything above the largest positive result is limited.
  assign clip_lim = s1_clip_reg[OUT_WIDTH-1] ? OUT_MAX : s1_clip_reg;

`ifdef ACTIVATION_FC_PIPE_SAT_STATS_EN
  logic [LANES-1:0] lane_sat;
`endif

  // ---------------------------------------------------------------------------
  // Per-lane datapath
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      // S1: rounding shift
      logic signed [EXT_WIDTH-1:0] x_ext;
      logic signed [EXT_WIDTH-1:0] half;

      assign x_ext = {acc_result_i[gi*IN_WIDTH + IN_WIDTH - 1],
                      acc_result_i[gi*IN_WIDTH +: IN_WIDTH]};
      // 2^(s-1); only used when s > 0, so the wrap of s-1 at s=0 is harmless.
      assign half  = EXT_WIDTH'(1) << (cfg_shift_i - SHIFT_WIDTH'(1));
      assign s1_r_next[gi] = (cfg_shift_i == '0) ? x_ext
                                                 : ((x_ext + half) >>> cfg_shift_i);

      // S2: activation and saturation
      logic signed [EXT_WIDTH-1:0] r;
      logic signed [EXT_WIDTH-1:0] pre;
      logic                        zero_out;
      logic                        over_hi;
      logic                        over_lo;
      logic [OUT_WIDTH-1:0]        sat_val;
      logic [OUT_WIDTH-1:0]        act_val;

      assign r = s1_r_reg[gi];

      // pre is the value presented to the saturator; zero_out forces the
      // negative half of ReLU-style modes to 0 before any clamping.
      always_comb begin
        pre      = r;
        zero_out = 1'b0;
        case (s1_mode_reg)
          MODE_RELU:  zero_out = r[EXT_WIDTH-1];
          MODE_LEAKY: if (r[EXT_WIDTH-1]) pre = r >>> LEAKY_SHIFT;
          MODE_CLIP:  zero_out = r[EXT_WIDTH-1];
          default:    ;
        endcase
      end

      assign over_hi = (pre > EXT_MAX);
      assign over_lo = (pre < EXT_MIN);
      assign sat_val = over_hi ? OUT_MAX : (over_lo ? OUT_MIN : pre[OUT_WIDTH-1:0]);

      // In clip mode the surviving value is non-negative, so an unsigned
      // compare against the clip limit is correct.
      always_comb begin
        if (zero_out) begin
          act_val = '0;
        end else if ((s1_mode_reg == MODE_CLIP) && (sat_val > clip_lim)) begin
          act_val = clip_lim;
        end else begin
          act_val = sat_val;
        end
      end

      assign s2_result_next[gi*OUT_WIDTH +: OUT_WIDTH] = act_val;

`ifdef ACTIVATION_FC_PIPE_SAT_STATS_EN
      // Only saturation clamps count; lanes zeroed by ReLU and clip-limit
      // clamps do not.
      assign lane_sat[gi] = !zero_out && (over_hi || over_lo);
`endif
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_last_reg   <= 1'b0;
      s1_mode_reg   <= MODE_BYPASS;
      s1_clip_reg   <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_r_reg[i] <= '0;
      end
      s2_valid_reg  <= 1'b0;
      s2_last_reg   <= 1'b0;
      s2_result_reg <= '0;
    end else begin
      if (acc_ready_o) begin
        s1_valid_reg <= acc_valid_i;
        if (acc_valid_i) begin
          s1_last_reg <= acc_last_i;
          s1_mode_reg <= mode_t'(cfg_mode_i);
          s1_clip_reg <= cfg_clip_i;
          for (int i = 0; i < LANES; i++) begin
            s1_r_reg[i] <= s1_r_next[i];
          end
        end
      end
      // Loading zeros when S1 is empty keeps the outputs gated to 0 while
      // act_valid_o is low without any extra output muxing.
      if (s2_load) begin
        s2_valid_reg  <= s1_valid_reg;
        s2_last_reg   <= s1_valid_reg && s1_last_reg;
        s2_result_reg <= s1_valid_reg ? s2_result_next : '0;
      end
    end
  end

  assign act_valid_o  = s2_valid_reg;
  assign act_last_o   = s2_last_reg;
  assign act_result_o = s2_result_reg;

`ifdef ACTIVATION_FC_PIPE_SAT_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturation statistics
  // ---------------------------------------------------------------------------
  localparam int CNT_WIDTH = $clog2(LANES + 1);

  logic [CNT_WIDTH-1:0] s2_sat_reg;
  logic [CNT_WIDTH-1:0] s2_sat_next;
  logic [15:0]          sat_acc_reg;
  logic [16:0]          sat_sum;
  logic [15:0]          sat_total;
  logic                 out_xfer;

  always_comb begin
    s2_sat_next = '0;
    for (int i = 0; i < LANES; i++) begin
      s2_sat_next = s2_sat_next + CNT_WIDTH'(lane_sat[i]);
    end
  end

  assign out_xfer  = s2_valid_reg && act_ready_i;
  assign sat_sum   = {1'b0, sat_acc_reg} + 17'(s2_sat_reg);
  assign sat_total = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_sat_reg        <= '0;
      sat_acc_reg       <= '0;
      sat_count_o       <= '0;
      sat_count_valid_o <= 1'b0;
    end else begin
      sat_count_valid_o <= 1'b0;
      // Per-beat count travels with the beat in S2 so it is added exactly
      // when that beat leaves the block.
      if (s2_load) begin
        s2_sat_reg <= s1_valid_reg ? s2_sat_next : '0;
      end
      if (out_xfer) begin
        if (s2_last_reg) begin
          sat_count_o       <= sat_total;
          sat_count_valid_o <= 1'b1;
          sat_acc_reg       <= '0;
        end else begin
          sat_acc_reg <= sat_total;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_activation_fc_pipe.sv
// -----------------------------------------------------------------------------
// Self-checking bench for activation_fc_pipe. A behavioural model computes the
// expected lanes from the requantise/activate rules with integer arithmetic;
// expected beats are queued on input transfers and compared on output
// transfers. Inputs change on the falling edge, outputs are sampled 1 ns
// later.
// -----------------------------------------------------------------------------
module tb_activation_fc_pipe;

  localparam int LANES   = 4;
  localparam int IN_W    = 16;
  localparam int OUT_W   = 8;
  localparam int SHIFT_W = 4;
  localparam int LEAKY   = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [1:0]              cfg_mode_i;
  logic [SHIFT_W-1:0]      cfg_shift_i;
  logic [OUT_W-1:0]        cfg_clip_i;
  logic                    acc_valid_i;
  logic                    acc_ready_o;
  logic                    acc_last_i;
  logic [LANES*IN_W-1:0]   acc_result_i;
  logic                    act_valid_o;
  logic                    act_ready_i;
  logic                    act_last_o;
  logic [LANES*OUT_W-1:0]  act_result_o;
`ifdef ACTIVATION_FC_PIPE_SAT_STATS_EN
  logic [15:0]             sat_count_o;
  logic                    sat_count_valid_o;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [LANES*OUT_W-1:0] data;
    logic                   last;
    int                     nsat;
  } beat_t;

  beat_t exp_q[$];

  always #5 clk = ~clk;

  activation_fc_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_mode_i   (cfg_mode_i),
    .cfg_shift_i  (cfg_shift_i),
    .cfg_clip_i   (cfg_clip_i),
    .acc_valid_i  (acc_valid_i),
    .acc_ready_o  (acc_ready_o),
    .acc_last_i   (acc_last_i),
    .acc_result_i (acc_result_i),
    .act_valid_o  (act_valid_o),
    .act_ready_i  (act_ready_i),
    .act_last_o   (act_last_o),
    .act_result_o (act_result_o)
`ifdef ACTIVATION_FC_PIPE_SAT_STATS_EN
    ,
    .sat_count_o       (sat_count_o),
    .sat_count_valid_o (sat_count_valid_o)
`endif
  );

  // Reference model: rounding shift, activation, saturation, clip.
  function automatic void model_beat(input logic [LANES*IN_W-1:0] x, input int shift,
                                     input int mode, input int clip,
                                     output logic [LANES*OUT_W-1:0] y, output int nsat);
    longint hi, lo, clip_eff;
    hi = (longint'(1) <<< (OUT_W - 1)) - 1;
    lo = -hi - 1;
    clip_eff = (clip > hi) ? hi : clip;
    y = '0;
    nsat = 0;
    for (int l = 0; l < LANES; l++) begin
      longint v, r, pre, res;
      logic [OUT_W-1:0] res_bits;
      bit zero;
      v = longint'($signed(x[l*IN_W +: IN_W]));
      r = (shift > 0) ? ((v + (longint'(1) <<< (shift - 1))) >>> shift) : v;
      zero = 1'b0;
      pre = r;
      if ((mode == 1 || mode == 3) && r < 0) zero = 1'b1;
      if (mode == 2 && r < 0) pre = r >>> LEAKY;
      if (!zero && (pre > hi || pre < lo)) nsat++;
      if (zero) res = 0;
      else if (pre > hi) res = hi;
      else if (pre < lo) res = lo;
      else res = pre;
      if (mode == 3 && !zero && res > clip_eff) res = clip_eff;
      res_bits = res[OUT_W-1:0];
      y[l*OUT_W +: OUT_W] = res_bits;
    end
  endfunction

  task automatic push_expected();
    beat_t b;
    logic [LANES*OUT_W-1:0] y;
    int n;
    model_beat(acc_result_i, int'(cfg_shift_i), int'(cfg_mode_i), int'(cfg_clip_i), y, n);
    b.data = y;
    b.nsat = n;
    b.last = acc_last_i;
    exp_q.push_back(b);
  endtask

  task automatic rand_beat(input bit rand_cfg);
    for (int l = 0; l < LANES; l++) begin
      logic [IN_W-1:0] lane;
      case ($urandom_range(0, 3))
        0:       lane = IN_W'($urandom_range(0, 400)) - IN_W'(200);
        1:       lane = IN_W'($urandom);
        2:       lane = ($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000;
        default: lane = IN_W'($urandom_range(0, 4000)) - IN_W'(2000);
      endcase
      acc_result_i[l*IN_W +: IN_W] = lane;
    end
    if (rand_cfg) begin
      cfg_mode_i  = 2'($urandom_range(0, 3));
      cfg_shift_i = SHIFT_W'($urandom_range(0, 15));
      cfg_clip_i  = OUT_W'($urandom);
    end
  endtask

  task automatic drive_idle();
    acc_valid_i  = 1'b0;
    acc_last_i   = 1'b0;
    acc_result_i = '0;
    act_ready_i  = 1'b1;
    cfg_mode_i   = 2'd0;
    cfg_shift_i  = '0;
    cfg_clip_i   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (act_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", act_valid_o); end
    checks++; if (act_last_o !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", act_last_o); end
    checks++; if (act_result_o !== '0) begin errors++; $display("FAIL reset_result: got %h expected 0", act_result_o); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (acc_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", acc_ready_o); end
    $display("reset released");
  endtask

  task automatic test_bypass();
    beat_t b;
    exp_q.delete();
    @(negedge clk);
    cfg_mode_i = 2'd0; cfg_shift_i = 4'd4; cfg_clip_i = '0;
    acc_result_i = {16'h7FFF, 16'hFFE8, 16'h0017, 16'h0018};
    acc_last_i = 1'b1; acc_valid_i = 1'b1; act_ready_i = 1'b1;
    #1;
    checks++; if (acc_ready_o !== 1'b1) begin errors++; $display("FAIL bypass_ready: got %b expected 1", acc_ready_o); end
    push_expected();
    @(posedge clk);
    @(negedge clk); acc_valid_i = 1'b0; acc_last_i = 1'b0; #1;
    checks++; if (act_valid_o !== 1'b0) begin errors++; $display("FAIL bypass_early: got %b expected 0", act_valid_o); end
    @(negedge clk); #1;
    b = exp_q.pop_front();
    checks++; if (act_valid_o !== 1'b1) begin errors++; $display("FAIL bypass_latency: got %b expected 1", act_valid_o); end
    checks++; if (act_result_o !== b.data) begin errors++; $display("FAIL bypass_data: got %h expected %h", act_result_o, b.data); end
    checks++; if (act_last_o !== 1'b1) begin errors++; $display("FAIL bypass_last: got %b expected 1", act_last_o); end
    $display("bypass beat: result %h expected %h", act_result_o, b.data);
    @(posedge clk);
    @(negedge clk); #1;
    checks++; if (act_valid_o !== 1'b0 || act_result_o !== '0) begin errors++; $display("FAIL bypass_gate: got valid %b data %h expected 0/0", act_valid_o, act_result_o); end
  endtask

  task automatic test_modes();
    int modes[4] = '{1, 2, 3, 3};
    int clips[4] = '{0, 0, 6, 255};
    beat_t b;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cfg_mode_i = 2'(modes[k]); cfg_shift_i = '0; cfg_clip_i = OUT_W'(clips[k]);
      acc_result_i = {16'hFFFF, 16'h00C8, 16'h0005, 16'hFFD8};
      acc_last_i = 1'b1; acc_valid_i = 1'b1; act_ready_i = 1'b1;
      #1;
      push_expected();
      @(posedge clk);
      @(negedge clk); acc_valid_i = 1'b0; #1;
      @(negedge clk); #1;
      b = exp_q.pop_front();
      checks++; if (act_valid_o !== 1'b1) begin errors++; $display("FAIL mode%0d_valid: got %b expected 1", modes[k], act_valid_o); end
      checks++; if (act_result_o !== b.data) begin errors++; $display("FAIL mode%0d_data clip %0d: got %h expected %h", modes[k], clips[k], act_result_o, b.data); end
      $display("mode %0d clip %0d: result %h expected %h", modes[k], clips[k], act_result_o, b.data);
      @(posedge clk);
    end
  endtask

  task automatic test_backpressure();
    int sent = 0, cyc = 0;
    bit pending = 1'b0, stalled = 1'b0, exp_ready;
    logic [LANES*OUT_W-1:0] hold_data;
    logic hold_last;
    beat_t b;
    exp_q.delete();
    while ((sent < 6 || exp_q.size() != 0) && cyc < 100) begin
      @(negedge clk);
      if (!pending && sent < 6) begin
        rand_beat(1'b1);
        acc_last_i = (sent == 5);
        acc_valid_i = 1'b1;
        pending = 1'b1;
      end else if (!pending) begin
        acc_valid_i = 1'b0;
      end
      act_ready_i = (cyc % 3 == 0);
      #1;
      if (stalled) begin
        checks++;
        if (act_valid_o !== 1'b1 || act_result_o !== hold_data || act_last_o !== hold_last) begin
          errors++; $display("FAIL bp_hold: got %b/%h/%b expected 1/%h/%b", act_valid_o, act_result_o, act_last_o, hold_data, hold_last);
        end
      end
      exp_ready = (exp_q.size() < 2) || act_ready_i;
      checks++; if (acc_ready_o !== exp_ready) begin errors++; $display("FAIL bp_ready cycle %0d: got %b expected %b", cyc, acc_ready_o, exp_ready); end
      if (act_valid_o && act_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra: got beat %h expected none", act_result_o);
        end else begin
          b = exp_q.pop_front();
          if (act_result_o !== b.data || act_last_o !== b.last) begin
            errors++; $display("FAIL bp_beat: got %h last %b expected %h last %b", act_result_o, act_last_o, b.data, b.last);
          end
          $display("bp out: %h last %b expected %h last %b", act_result_o, act_last_o, b.data, b.last);
        end
      end
      stalled = act_valid_o && !act_ready_i;
      hold_data = act_result_o;
      hold_last = act_last_o;
      if (acc_valid_i && acc_ready_o) begin
        push_expected();
        sent++;
        pending = 1'b0;
      end
      @(posedge clk);
      cyc++;
    end
    acc_valid_i = 1'b0;
    checks++; if (sent != 6 || exp_q.size() != 0) begin errors++; $display("FAIL bp_timeout: got sent %0d pending %0d expected 6/0", sent, exp_q.size()); end
  endtask

  task automatic test_last_config();
    int got = 0;
    beat_t b;
    exp_q.delete();
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      act_ready_i = 1'b1;
      if (cyc < 3) begin
        acc_result_i = {16'hFFEC, 16'h0030, 16'hFFEC, 16'h0300};
        cfg_shift_i = '0;
        cfg_clip_i = 8'd10;
        cfg_mode_i = (cyc == 0) ? 2'd0 : 2'd3;
        acc_last_i = (cyc == 2);
        acc_valid_i = 1'b1;
      end else begin
        acc_valid_i = 1'b0;
        acc_last_i = 1'b0;
      end
      #1;
      if (act_valid_o && act_ready_i) begin
        b = exp_q.pop_front();
        got++;
        checks++; if (act_result_o !== b.data) begin errors++; $display("FAIL lastcfg_data beat %0d: got %h expected %h", got, act_result_o, b.data); end
        checks++; if (act_last_o !== b.last) begin errors++; $display("FAIL lastcfg_last beat %0d: got %b expected %b", got, act_last_o, b.last); end
        $display("lastcfg out %0d: %h last %b expected %h last %b", got, act_result_o, act_last_o, b.data, b.last);
      end
      if (acc_valid_i && acc_ready_o) push_expected();
      @(posedge clk);
    end
    checks++; if (got != 3) begin errors++; $display("FAIL lastcfg_count: got %0d expected 3", got); end
  endtask

  task automatic test_random_stream();
    int sent = 0, cyc = 0;
    bit pending = 1'b0;
    beat_t b;
    exp_q.delete();
    while ((sent < 300 || exp_q.size() != 0) && cyc < 4000) begin
      @(negedge clk);
      if (!pending && sent < 300 && $urandom_range(0, 9) < 7) begin
        rand_beat(1'b1);
        acc_last_i = ($urandom_range(0, 3) == 0);
        acc_valid_i = 1'b1;
        pending = 1'b1;
      end else if (!pending) begin
        acc_valid_i = 1'b0;
      end
      act_ready_i = ($urandom_range(0, 9) < 7);
      #1;
      if (!act_valid_o) begin
        checks++;
        if (act_result_o !== '0 || act_last_o !== 1'b0) begin errors++; $display("FAIL rand_gate: got %h last %b expected 0", act_result_o, act_last_o); end
      end else if (act_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra: got beat %h expected none", act_result_o);
        end else begin
          b = exp_q.pop_front();
          if (act_result_o !== b.data || act_last_o !== b.last) begin
            errors++; $display("FAIL rand_beat: got %h last %b expected %h last %b", act_result_o, act_last_o, b.data, b.last);
          end
        end
      end
      if (acc_valid_i && acc_ready_o) begin
        push_expected();
        sent++;
        pending = 1'b0;
      end
      @(posedge clk);
      cyc++;
    end
    acc_valid_i = 1'b0;
    checks++; if (sent != 300 || exp_q.size() != 0) begin errors++; $display("FAIL rand_timeout: got sent %0d pending %0d expected 300/0", sent, exp_q.size()); end
    $display("random stream: %0d beats in %0d cycles", sent, cyc);
  endtask

  task automatic test_reset_midstream();
    beat_t b;
    exp_q.delete();
    act_ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      rand_beat(1'b0);
      acc_last_i = 1'b0;
      acc_valid_i = 1'b1;
      @(posedge clk);
    end
    @(negedge clk); acc_valid_i = 1'b0; #1;
    checks++; if (act_valid_o !== 1'b1) begin errors++; $display("FAIL midrst_fill: got %b expected 1", act_valid_o); end
    checks++; if (acc_ready_o !== 1'b0) begin errors++; $display("FAIL midrst_full: got %b expected 0", acc_ready_o); end
    rst = 1'b1;
    #1;
    checks++; if (act_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", act_valid_o); end
    checks++; if (act_result_o !== '0 || act_last_o !== 1'b0) begin errors++; $display("FAIL midrst_data: got %h last %b expected 0", act_result_o, act_last_o); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    act_ready_i = 1'b1;
    rand_beat(1'b1);
    acc_last_i = 1'b1;
    acc_valid_i = 1'b1;
    #1;
    checks++; if (acc_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", acc_ready_o); end
    push_expected();
    @(posedge clk);
    @(negedge clk); acc_valid_i = 1'b0; acc_last_i = 1'b0; #1;
    checks++; if (act_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_early: got %b expected 0", act_valid_o); end
    @(negedge clk); #1;
    b = exp_q.pop_front();
    checks++; if (act_valid_o !== 1'b1 || act_result_o !== b.data || act_last_o !== 1'b1) begin
      errors++; $display("FAIL midrst_beat: got %b/%h/%b expected 1/%h/1", act_valid_o, act_result_o, act_last_o, b.data);
    end
    $display("post-reset beat: %h expected %h", act_result_o, b.data);
    @(posedge clk);
  endtask

`ifdef ACTIVATION_FC_PIPE_SAT_STATS_EN
  task automatic test_sat_stats();
    logic [LANES*IN_W-1:0] beats[3];
    logic lasts[3] = '{1'b0, 1'b1, 1'b1};
    int idx = 0, acc = 0, exp_count = 0, pulses = 0;
    bit exp_pulse = 1'b0;
    beat_t b;
    beats[0] = {16'h0005, 16'h03E8, 16'hFED4, 16'h012C};
    beats[1] = {16'h0003, 16'h0002, 16'h0001, 16'h00C8};
    beats[2] = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    exp_q.delete();
    @(negedge clk); rst = 1'b1; drive_idle();
    @(negedge clk); rst = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      act_ready_i = 1'b1;
      cfg_mode_i = 2'd0; cfg_shift_i = '0;
      if (idx < 3) begin
        acc_result_i = beats[idx]; acc_last_i = lasts[idx]; acc_valid_i = 1'b1;
      end else begin
        acc_valid_i = 1'b0; acc_last_i = 1'b0;
      end
      #1;
      checks++; if (sat_count_valid_o !== exp_pulse) begin errors++; $display("FAIL stats_pulse cycle %0d: got %b expected %b", cyc, sat_count_valid_o, exp_pulse); end
      if (exp_pulse) begin
        pulses++;
        checks++; if (sat_count_o !== 16'(exp_count)) begin errors++; $display("FAIL stats_count: got %0d expected %0d", sat_count_o, exp_count); end
        $display("stats frame: count %0d expected %0d", sat_count_o, exp_count);
      end
      exp_pulse = 1'b0;
      if (act_valid_o && act_ready_i && exp_q.size() != 0) begin
        b = exp_q.pop_front();
        checks++; if (act_result_o !== b.data) begin errors++; $display("FAIL stats_data: got %h expected %h", act_result_o, b.data); end
        acc = (acc + b.nsat > 65535) ? 65535 : acc + b.nsat;
        if (b.last) begin exp_pulse = 1'b1; exp_count = acc; acc = 0; end
      end
      if (acc_valid_i && acc_ready_o) begin push_expected(); idx++; end
      @(posedge clk);
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL stats_pulses: got %0d expected 2", pulses); end
  endtask
`endif

  initial begin
    drive_idle();
    rst = 1'b1;
    test_reset();
    test_bypass();
    test_modes();
    test_backpressure();
    test_last_config();
    test_random_stream();
    test_reset_midstream();
`ifdef ACTIVATION_FC_PIPE_SAT_STATS_EN
    test_sat_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
